// File: rtl/if_id_stage_if.sv
// Instruction-memory fetch bus between the IF stage and instruction memory.
// Zero-latency protocol: rdata is valid in the same cycle whenever ready is high.
interface if_id_stage_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);
  logic [ADDR_W-1:0] addr;
  logic              req;
  logic              ready;
  logic [INST_W-1:0] rdata;

  // The fetch stage drives the address and request, and the memory answers.
  modport master (output addr, output req, input ready, input rdata);
  modport slave  (input addr, input req, output ready, output rdata);
endinterface

// File: rtl/if_id_stage.sv
// IF stage plus the IF/ID pipeline register.
// Owns the PC, issues fetches, and applies redirect, stall and bubble rules.
// Keeps saturating debug counters for stall and flush events.
module if_id_stage #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [INST_W-1:0] NOP      = 32'h0000_0013,
  parameter int                CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hold_flag,
  input  logic               jump_flag,
  input  logic [ADDR_W-1:0]  jump_addr,
  if_id_stage_if.master      imem,
  output logic [INST_W-1:0]  id_inst,
  output logic [ADDR_W-1:0]  id_pc,
  output logic               id_valid,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  typedef enum logic [0:0] {
    S_BOOT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // The low two bits of a redirect target are forced to zero.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};
  localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};

  state_t              state_q;
  logic                imem_req_q;
  logic [ADDR_W-1:0]   pc_q,        pc_d;
  logic [INST_W-1:0]   id_inst_q,   id_inst_d;
  logic [ADDR_W-1:0]   id_pc_q,     id_pc_d;
  logic                id_valid_q,  id_valid_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;

  // Saturating increment: once the counter reaches all-ones it stays there.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  // Boot/run controller: one idle cycle after reset, after which it runs until the next reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_BOOT;
      imem_req_q <= 1'b0;
    end else begin
      case (state_q)
        S_BOOT: begin
          state_q    <= S_RUN;
          imem_req_q <= 1'b1;
        end
        S_RUN: begin
          state_q    <= S_RUN;
          imem_req_q <= 1'b1;
        end
        default: begin
          state_q    <= S_BOOT;
          imem_req_q <= 1'b0;
        end
      endcase
    end
  end

  // Next-state logic for PC, IF/ID and the counters. The priority is redirect, then stall, then bubble, then advance.
  always_comb begin
    pc_d        = pc_q;
    id_inst_d   = id_inst_q;
    id_pc_d     = id_pc_q;
    id_valid_d  = id_valid_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (state_q == S_RUN) begin
      if (jump_flag) begin
        // The instruction fetched this cycle is on the wrong path.
        pc_d        = jump_addr & ALIGN_MASK;
        id_inst_d   = NOP;
        id_valid_d  = 1'b0;
        flush_cnt_d = sat_inc(flush_cnt_q);
      end else if (hold_flag) begin
        // Load-use stall: freeze PC and IF/ID together.
        stall_cnt_d = sat_inc(stall_cnt_q);
      end else if (!imem.ready) begin
        // No data from memory: send a bubble and retry the same PC.
        id_inst_d  = NOP;
        id_valid_d = 1'b0;
      end else begin
        id_inst_d  = imem.rdata;
        id_pc_d    = pc_q;
        id_valid_d = 1'b1;
        pc_d       = pc_q + ADDR_W'(4);
      end
    end else begin
      // While booting, hold the PC and keep NOP in IF/ID.
      pc_d = pc_q;
    end
  end

  // Datapath and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      id_inst_q   <= NOP;
      id_pc_q     <= {ADDR_W{1'b0}};
      id_valid_q  <= 1'b0;
      stall_cnt_q <= {CNT_W{1'b0}};
      flush_cnt_q <= {CNT_W{1'b0}};
    end else begin
      pc_q        <= pc_d;
      id_inst_q   <= id_inst_d;
      id_pc_q     <= id_pc_d;
      id_valid_q  <= id_valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign imem.addr = pc_q;
  assign imem.req  = imem_req_q;
  assign id_inst   = id_inst_q;
  assign id_pc     = id_pc_q;
  assign id_valid  = id_valid_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
